// File: rtl/dll_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : dll_tx_sched
// Description : Data link layer transmit scheduler. Merges one TLP beat
//               stream with NUM_DLLP_SRC single-beat DLLP sources onto the
//               PIPE TX path. It never splits a TLP, stamps each TLP with a
//               sequence number and bounds starvation in both directions.
//               Optional statistics counters: DLL_TX_SCHED_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dll_tx_sched #(
    parameter int DATA_WIDTH   = 256,
    parameter int NUM_DLLP_SRC = 2,
    parameter int STARVE_LIMIT = 8,
    parameter int SEQ_WIDTH    = 12
) (
    input  logic                                 sclk,
    input  logic                                 srst_n,
    input  logic                                 link_up_i,
    input  logic [DATA_WIDTH-1:0]                tlp_data_i,
    input  logic [2:0]                           tlp_en_i,
    output logic                                 tlp_ready_o,
    input  logic [NUM_DLLP_SRC-1:0]              dllp_valid_i,
    input  logic [NUM_DLLP_SRC*DATA_WIDTH-1:0]   dllp_data_i,
    output logic [NUM_DLLP_SRC-1:0]              dllp_ready_o,
    output logic [DATA_WIDTH-1:0]                tx_data_o,
    output logic                                 tx_valid_o,
    output logic                                 tx_sop_o,
    output logic                                 tx_eop_o,
    output logic                                 tx_is_dllp_o,
    output logic [SEQ_WIDTH-1:0]                 tx_seq_o,
    output logic                                 proto_err_o,
`ifdef DLL_TX_SCHED_STATS_EN
    output logic [31:0]                          stat_tlp_cnt_o,
    output logic [31:0]                          stat_dllp_cnt_o,
`endif
    output logic                                 abort_o
);

    localparam int PTR_W = (NUM_DLLP_SRC > 1) ? $clog2(NUM_DLLP_SRC) : 1;
    localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic [2:0] CODE_IDLE     = 3'd0;
    localparam logic [2:0] CODE_P_HDR    = 3'd1;
    localparam logic [2:0] CODE_P_DATA   = 3'd2;
    localparam logic [2:0] CODE_NP_HDR   = 3'd3;
    localparam logic [2:0] CODE_RSVD     = 3'd4;
    localparam logic [2:0] CODE_CPL_HDR  = 3'd5;
    localparam logic [2:0] CODE_CPL_DATA = 3'd6;
    localparam logic [2:0] CODE_DONE     = 3'd7;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_TLP  = 1'b1
    } state_t;

    state_t                  state_q;
    logic [PTR_W-1:0]        rr_q;
    logic [PTR_W-1:0]        rr_d;
    logic [STV_W-1:0]        starve_q;
    logic [SEQ_WIDTH-1:0]    seq_q;
    logic [DATA_WIDTH-1:0]   tx_data_q;
    logic                    tx_valid_q;
    logic                    tx_sop_q;
    logic                    tx_eop_q;
    logic                    tx_is_dllp_q;
    logic [SEQ_WIDTH-1:0]    tx_seq_q;
    logic                    proto_err_q;
    logic                    abort_q;

    logic                    w_hdr;
    logic                    w_data_code;
    logic                    w_illegal;
    logic                    w_found;
    logic [PTR_W-1:0]        w_grant_idx;
    logic [DATA_WIDTH-1:0]   w_dllp_data;
    logic                    w_dllp_gnt;
    logic                    w_hdr_acc;
    logic                    w_beat_acc;
    logic                    w_drop;

    // Beat-code classification and acceptance decisions for this cycle.
    always_comb begin
        w_hdr       = (tlp_en_i == CODE_P_HDR) || (tlp_en_i == CODE_NP_HDR) ||
                      (tlp_en_i == CODE_CPL_HDR);
        w_data_code = (tlp_en_i == CODE_P_DATA) || (tlp_en_i == CODE_CPL_DATA) ||
                      (tlp_en_i == CODE_DONE);
        w_illegal   = (tlp_en_i == CODE_RSVD) ||
                      ((state_q == S_TLP) && w_hdr) ||
                      ((state_q == S_IDLE) && w_data_code);
        // A waiting header only yields to DLLPs until the starve budget runs out.
        w_dllp_gnt  = link_up_i && (state_q == S_IDLE) && w_found &&
                      (!w_hdr || (starve_q < STV_W'(STARVE_LIMIT)));
        w_hdr_acc   = link_up_i && (state_q == S_IDLE) && w_hdr && !w_dllp_gnt;
        w_beat_acc  = link_up_i && (state_q == S_TLP) && w_data_code;
        // Illegal beats are swallowed so the TL side cannot lock up on them.
        w_drop      = link_up_i && w_illegal;
        tlp_ready_o = w_hdr_acc || w_beat_acc || w_drop;
    end

    // Round-robin search: first requester at or above the pointer, then wrap.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NUM_DLLP_SRC; k++) begin
            if (!w_found && dllp_valid_i[k] && (k >= int'(rr_q))) begin
                w_found     = 1'b1;
                w_grant_idx = PTR_W'(k);
            end
        end
        for (int k = 0; k < NUM_DLLP_SRC; k++) begin
            if (!w_found && dllp_valid_i[k]) begin
                w_found     = 1'b1;
                w_grant_idx = PTR_W'(k);
            end
        end
        rr_d = (w_grant_idx == PTR_W'(NUM_DLLP_SRC - 1)) ? '0 : w_grant_idx + 1'b1;
    end

    // Select the payload of the granted DLLP source.
    always_comb begin
        w_dllp_data = '0;
        for (int k = 0; k < NUM_DLLP_SRC; k++) begin
            if (w_grant_idx == PTR_W'(k)) begin
                w_dllp_data = dllp_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DLLP_SRC; g++) begin : g_grant
            assign dllp_ready_o[g] = w_dllp_gnt && (w_grant_idx == PTR_W'(g));
        end
    endgenerate

    // Scheduler FSM with registered PIPE TX outputs, counters and status flags.
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state_q      <= S_IDLE;
            rr_q         <= '0;
            starve_q     <= '0;
            seq_q        <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            tx_sop_q     <= 1'b0;
            tx_eop_q     <= 1'b0;
            tx_is_dllp_q <= 1'b0;
            tx_seq_q     <= '0;
            proto_err_q  <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            tx_valid_q   <= 1'b0;
            tx_sop_q     <= 1'b0;
            tx_eop_q     <= 1'b0;
            tx_is_dllp_q <= 1'b0;
            abort_q      <= 1'b0;
            if (!link_up_i) begin
                // Link loss cuts an in-flight TLP; its sequence number is reused.
                if (state_q == S_TLP) begin
                    state_q <= S_IDLE;
                    abort_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (w_dllp_gnt) begin
                            tx_data_q    <= w_dllp_data;
                            tx_valid_q   <= 1'b1;
                            tx_sop_q     <= 1'b1;
                            tx_eop_q     <= 1'b1;
                            tx_is_dllp_q <= 1'b1;
                            tx_seq_q     <= '0;
                            rr_q         <= rr_d;
                            if (w_hdr) begin
                                starve_q <= starve_q + 1'b1;
                            end
                        end else if (w_hdr_acc) begin
                            tx_data_q  <= tlp_data_i;
                            tx_valid_q <= 1'b1;
                            tx_sop_q   <= 1'b1;
                            tx_seq_q   <= seq_q;
                            starve_q   <= '0;
                            state_q    <= S_TLP;
                        end
                    end
                    S_TLP: begin
                        if (w_beat_acc) begin
                            tx_data_q  <= tlp_data_i;
                            tx_valid_q <= 1'b1;
                            tx_seq_q   <= seq_q;
                            if (tlp_en_i == CODE_DONE) begin
                                tx_eop_q <= 1'b1;
                                seq_q    <= seq_q + 1'b1;
                                state_q  <= S_IDLE;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
                if (w_drop) begin
                    proto_err_q <= 1'b1;
                end
            end
        end
    end

    assign tx_data_o    = tx_data_q;
    assign tx_valid_o   = tx_valid_q;
    assign tx_sop_o     = tx_sop_q;
    assign tx_eop_o     = tx_eop_q;
    assign tx_is_dllp_o = tx_is_dllp_q;
    assign tx_seq_o     = tx_seq_q;
    assign proto_err_o  = proto_err_q;
    assign abort_o      = abort_q;

`ifdef DLL_TX_SCHED_STATS_EN
    logic [31:0] stat_tlp_q;
    logic [31:0] stat_dllp_q;

    // Saturating counts of completed TLPs and issued DLLPs.
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            stat_tlp_q  <= '0;
            stat_dllp_q <= '0;
        end else begin
            if (w_beat_acc && (tlp_en_i == CODE_DONE) && (stat_tlp_q != 32'hFFFF_FFFF)) begin
                stat_tlp_q <= stat_tlp_q + 32'd1;
            end
            if (w_dllp_gnt && (stat_dllp_q != 32'hFFFF_FFFF)) begin
                stat_dllp_q <= stat_dllp_q + 32'd1;
            end
        end
    end

    assign stat_tlp_cnt_o  = stat_tlp_q;
    assign stat_dllp_cnt_o = stat_dllp_q;
`endif

endmodule
`default_nettype wire

// File: doc/dll_tx_sched.md
Name: dll_tx_sched

Overview:
Parametrised transmit scheduler for the data link layer. It merges one TL-side TLP beat stream with NUM_DLLP_SRC DLLP sources onto the single PIPE transmit path. It never interleaves DLLPs inside a TLP, assigns a TLP sequence number, and prevents starvation of both TLPs and DLLPs. It sits between the TL/retry path and the PIPE TX, and generalises the fixed two-source TLP/DLLP arbitration in the current DLL.

Parameters:
DATA_WIDTH, 256, beat width of TLP, DLLP and PIPE TX data
NUM_DLLP_SRC, 2, number of DLLP request sources (1..8)
STARVE_LIMIT, 8, consecutive DLLP grants allowed while a TLP header waits
SEQ_WIDTH, 12, TLP sequence number width

Ports:
sclk  in  1  clock
srst_n  in  1  asynchronous active-low reset
link_up_i  in  1  DLCMSM in DL_Active
tlp_data_i  in  DATA_WIDTH  TLP beat
tlp_en_i  in  3  beat code: 0 IDLE, 1 P_HDR, 2 P_DATA, 3 NP_HDR, 4 RESERVED, 5 CPL_HDR, 6 CPL_DATA, 7 DONE (last beat)
tlp_ready_o  out  1  beat accepted this cycle when tlp_en_i!=0
dllp_valid_i  in  NUM_DLLP_SRC  per-source request
dllp_data_i  in  NUM_DLLP_SRC*DATA_WIDTH  source k at bits [k*DATA_WIDTH +: DATA_WIDTH]
dllp_ready_o  out  NUM_DLLP_SRC  one-hot grant
tx_data_o  out  DATA_WIDTH  PIPE TX data
tx_valid_o  out  1  PIPE TX valid
tx_sop_o / tx_eop_o  out  1 each  first / last beat of packet (both high for DLLP)
tx_is_dllp_o  out  1  current beat is a DLLP
tx_seq_o  out  SEQ_WIDTH  sequence number of current TLP (0 for DLLP)
proto_err_o  out  1  sticky: illegal beat code seen
abort_o  out  1  one-cycle pulse: TLP cut by link-down

Behaviour:
- Reset: all outputs 0; state IDLE; seq counter 0; starve counter 0; RR pointer 0.
- FSM states: IDLE, TLP. DLLPs are single-beat and are issued from IDLE only.
- IDLE, link_up_i=1: header pending = tlp_en_i in {1,3,5}. Any DLLP valid and (no header pending or starve_cnt<STARVE_LIMIT) -> grant DLLP, round-robin starting at RR pointer; pointer = granted+1 mod NUM_DLLP_SRC; starve_cnt++ if header pending. Otherwise, if header pending -> tlp_ready_o=1, starve_cnt=0, go TLP (stay IDLE if the header beat also has code 7? no: a header beat is never last; NP TLP ends with a code-7 beat).
- TLP: tlp_ready_o=1 for codes 2,6,7; code 7 -> IDLE and seq++ (wraps 2^SEQ_WIDTH-1 -> 0). Code 0 -> bubble, no output, stay TLP. No DLLP grant while in TLP.
- Illegal codes: 4 anywhere; header code in TLP; 2/6/7 in IDLE. The beat is consumed (ready=1) and dropped, proto_err_o set, state unchanged.
- tlp_ready_o and dllp_ready_o are combinational from state/inputs; output registers load on acceptance. Latency is exactly 1 cycle; tx_valid_o=0 in cycles with no acceptance.
- tx_seq_o is held for all beats of a TLP.
- link_up_i=0: no grants, ready outputs 0. If in TLP: go IDLE, pulse abort_o next cycle, tx_valid_o=0, seq not incremented.
- Async reset mid-packet: immediate return to reset values.

Optional Feature:
DLL_TX_SCHED_STATS_EN: when defined, adds outputs stat_tlp_cnt_o[31:0] (++ per completed TLP) and stat_dllp_cnt_o[31:0] (++ per DLLP). Both saturate at 0xFFFFFFFF and reset to 0. Without the macro, these ports and counters do not exist.

Test Plan:
- TLP 1,2,2,7 with link up -> 4 tx beats 1 cycle later, sop on beat0, eop on beat3, tx_seq_o=0; next TLP carries seq 1.
- Both DLLP sources held valid, no TLP -> grants alternate 01,10,01,10; each beat has sop=eop=is_dllp=1.
- DLLP src0 held valid plus header pending, STARVE_LIMIT=8 -> 8 DLLP grants, then TLP header accepted, starve_cnt cleared.
- DLLP asserted mid-TLP 5,6,7 -> DLLP granted only in the cycle after the code-7 beat.
- Preload seq 4095, send TLP -> seq 4095 on it, next TLP gets 0. link_up_i dropped after 2nd beat of 1,2,2,7 -> abort_o pulse, seq unchanged.
- Inject code 4 in IDLE -> beat dropped, proto_err_o=1 and remains 1 until reset.
